// File: rtl/bakraid_snd_host.sv
// bakraid_snd_host
//    Host-side (68k) interface to the Bakraid sound CPU. The 68k writes two
//    command bytes and then fires a trigger. The trigger raises the CS/NMI
//    strobes for PULSE_W cycles. The block then reports BUSY until the sound
//    side has raised WAIT and dropped it again. Writes that would disturb an
//    active transfer (offsets 0, 1, 5) are held off by withholding DTACK.
//
//    Register map (M68_ADDR):
//       0 W SOUNDLATCH       1 W SOUNDLATCH2
//       2 R SOUNDLATCH3      3 R SOUNDLATCH4
//       4 R status {5'b0, TOUT, IRQP, BUSY}
//       5 W trigger          6 W IRQ acknowledge
//       other offsets read 8'hFF, and writes to them are ignored
//
//    Parameters:
//       PULSE_W  CS/NMI pulse width in CLK96 cycles (2..255)
//       TIMEOUT  acknowledge watchdog limit in CLK96 cycles
//
//    Ports:
//       CLK96, RESET96_N                clock, async active-low reset
//       M68_CS/RW/ADDR/DIN              68k register access (CS is a level)
//       M68_DOUT, M68_DTACK_N           registered read data, acknowledge
//       M68_IRQ_N                       sound-to-host interrupt (registered)
//       SOUNDLATCH, SOUNDLATCH2         command bytes to the sound CPU
//       CS, NMI                         command strobes to the sound side
//       WAIT, SNDIRQ                    sound busy level, 1-cycle IRQ pulse
//       SOUNDLATCH3, SOUNDLATCH4        reply bytes from the sound CPU
//
//    Optional feature: define BAKRAID_SND_TIMEOUT_EN to add the watchdog.
//    The watchdog forces the FSM back to IDLE after TIMEOUT busy cycles and
//    sets TOUT. Without the macro, ACKWAIT waits indefinitely and TOUT
//    reads 0.
module bakraid_snd_host #(
   parameter int PULSE_W = 8,
   parameter int TIMEOUT = 960000
) (
   input  logic       CLK96,
   input  logic       RESET96_N,
   input  logic       M68_CS,
   input  logic       M68_RW,
   input  logic [2:0] M68_ADDR,
   input  logic [7:0] M68_DIN,
   output logic [7:0] M68_DOUT,
   output logic       M68_DTACK_N,
   output logic       M68_IRQ_N,
   output logic [7:0] SOUNDLATCH,
   output logic [7:0] SOUNDLATCH2,
   output logic       CS,
   output logic       NMI,
   input  logic       WAIT,
   input  logic       SNDIRQ,
   input  logic [7:0] SOUNDLATCH3,
   input  logic [7:0] SOUNDLATCH4
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_ACKWAIT = 2'd2
   } state_t;

   localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);

   state_t     state_r;
   logic [7:0] pulse_cnt_r;
   logic       seen_r;
   logic       irqp_r;
   logic       done_r;       // current CS assertion has already been served

   logic       busy_s;
   logic       stall_addr_s;
   logic       stall_s;
   logic       accept_s;
   logic       wr_s;
   logic       rd_s;
   logic       trig_s;
   logic       ack_s;
   logic       irqp_next_s;
   logic       tout_s;
   logic [7:0] status_s;
   logic [7:0] rd_data_s;

`ifdef BAKRAID_SND_TIMEOUT_EN
   localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT - 1);
   logic        tout_r;
   logic [31:0] tout_cnt_r;
   assign tout_s = tout_r;
`else
   assign tout_s = 1'b0;
`endif

   // Access decode: decide if this cycle serves the pending 68k access
   always_comb begin
      busy_s       = (state_r != ST_IDLE);
      stall_addr_s = 1'b0;
      case (M68_ADDR)
         3'd0, 3'd1, 3'd5: stall_addr_s = 1'b1;
         default:          stall_addr_s = 1'b0;
      endcase
      stall_s  = !M68_RW && stall_addr_s && busy_s;
      accept_s = M68_CS && !done_r && !stall_s;
      wr_s     = accept_s && !M68_RW;
      rd_s     = accept_s && M68_RW;
      // Stalled addresses include 5, so a committed trigger always lands in IDLE
      trig_s   = wr_s && (M68_ADDR == 3'd5);
      ack_s    = wr_s && (M68_ADDR == 3'd6);
      // A new SNDIRQ pulse wins over a simultaneous acknowledge
      if (SNDIRQ) begin
         irqp_next_s = 1'b1;
      end else if (ack_s) begin
         irqp_next_s = 1'b0;
      end else begin
         irqp_next_s = irqp_r;
      end
      status_s = {5'b00000, tout_s, irqp_r, busy_s};
      case (M68_ADDR)
         3'd2:    rd_data_s = SOUNDLATCH3;
         3'd3:    rd_data_s = SOUNDLATCH4;
         3'd4:    rd_data_s = status_s;
         default: rd_data_s = 8'hFF;
      endcase
   end

   // Bus side: acknowledge handshake, read data, command latches, IRQ flag
   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         M68_DOUT    <= 8'hFF;
         M68_DTACK_N <= 1'b1;
         M68_IRQ_N   <= 1'b1;
         done_r      <= 1'b0;
         irqp_r      <= 1'b0;
         SOUNDLATCH  <= 8'h00;
         SOUNDLATCH2 <= 8'h00;
      end else begin
         if (!M68_CS) begin
            done_r      <= 1'b0;
            M68_DTACK_N <= 1'b1;
         end else if (accept_s) begin
            done_r      <= 1'b1;
            M68_DTACK_N <= 1'b0;
         end else begin
            done_r      <= done_r;
            M68_DTACK_N <= M68_DTACK_N;
         end
         if (rd_s) begin
            M68_DOUT <= rd_data_s;
         end else begin
            M68_DOUT <= M68_DOUT;
         end
         if (wr_s && (M68_ADDR == 3'd0)) begin
            SOUNDLATCH <= M68_DIN;
         end else begin
            SOUNDLATCH <= SOUNDLATCH;
         end
         if (wr_s && (M68_ADDR == 3'd1)) begin
            SOUNDLATCH2 <= M68_DIN;
         end else begin
            SOUNDLATCH2 <= SOUNDLATCH2;
         end
         irqp_r    <= irqp_next_s;
         M68_IRQ_N <= !irqp_next_s;
      end
   end

   // Transfer FSM: IDLE -> PULSE (CS/NMI strobes) -> ACKWAIT -> IDLE
   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         state_r     <= ST_IDLE;
         pulse_cnt_r <= 8'd0;
         seen_r      <= 1'b0;
         CS          <= 1'b0;
         NMI         <= 1'b0;
`ifdef BAKRAID_SND_TIMEOUT_EN
         tout_r      <= 1'b0;
         tout_cnt_r  <= 32'd0;
`endif
      end else begin
         if (busy_s && WAIT) begin
            seen_r <= 1'b1;
         end else begin
            seen_r <= seen_r;
         end
`ifdef BAKRAID_SND_TIMEOUT_EN
         if (busy_s) begin
            tout_cnt_r <= tout_cnt_r + 32'd1;
         end else begin
            tout_cnt_r <= 32'd0;
         end
`endif
         case (state_r)
            ST_IDLE: begin
               if (trig_s) begin
                  state_r     <= ST_PULSE;
                  pulse_cnt_r <= 8'd0;
                  seen_r      <= 1'b0;
                  CS          <= 1'b1;
                  NMI         <= 1'b1;
`ifdef BAKRAID_SND_TIMEOUT_EN
                  tout_r      <= 1'b0;
                  tout_cnt_r  <= 32'd0;
`endif
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_PULSE: begin
               // Strobes stay high for exactly the PULSE state's residency
               if (pulse_cnt_r == PULSE_LAST) begin
                  state_r     <= ST_ACKWAIT;
                  pulse_cnt_r <= 8'd0;
                  CS          <= 1'b0;
                  NMI         <= 1'b0;
               end else begin
                  pulse_cnt_r <= pulse_cnt_r + 8'd1;
               end
            end
            ST_ACKWAIT: begin
               // Done once the sound side has shown busy and released it
               if (seen_r && !WAIT) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_ACKWAIT;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               pulse_cnt_r <= 8'd0;
               CS          <= 1'b0;
               NMI         <= 1'b0;
            end
         endcase
`ifdef BAKRAID_SND_TIMEOUT_EN
         // Watchdog overrides the normal flow: tout_cnt_r == k-1 on the k-th busy edge
         if (busy_s && (tout_cnt_r == TOUT_LAST)) begin
            state_r     <= ST_IDLE;
            pulse_cnt_r <= 8'd0;
            CS          <= 1'b0;
            NMI         <= 1'b0;
            tout_r      <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_bakraid_snd_host.sv
// Directed self-checking bench for bakraid_snd_host (PULSE_W=8, TIMEOUT=100).
module tb_bakraid_snd_host;

   logic       CLK96 = 1'b0;
   logic       RESET96_N;
   logic       M68_CS;
   logic       M68_RW;
   logic [2:0] M68_ADDR;
   logic [7:0] M68_DIN;
   logic [7:0] M68_DOUT;
   logic       M68_DTACK_N;
   logic       M68_IRQ_N;
   logic [7:0] SOUNDLATCH;
   logic [7:0] SOUNDLATCH2;
   logic       CS;
   logic       NMI;
   logic       WAIT;
   logic       SNDIRQ;
   logic [7:0] SOUNDLATCH3;
   logic [7:0] SOUNDLATCH4;

   int total = 0;
   int bad   = 0;

   bakraid_snd_host #(.PULSE_W(8), .TIMEOUT(100)) dut (
      .CLK96(CLK96), .RESET96_N(RESET96_N),
      .M68_CS(M68_CS), .M68_RW(M68_RW), .M68_ADDR(M68_ADDR), .M68_DIN(M68_DIN),
      .M68_DOUT(M68_DOUT), .M68_DTACK_N(M68_DTACK_N), .M68_IRQ_N(M68_IRQ_N),
      .SOUNDLATCH(SOUNDLATCH), .SOUNDLATCH2(SOUNDLATCH2), .CS(CS), .NMI(NMI),
      .WAIT(WAIT), .SNDIRQ(SNDIRQ),
      .SOUNDLATCH3(SOUNDLATCH3), .SOUNDLATCH4(SOUNDLATCH4)
   );

   always #5 CLK96 = ~CLK96;

   // Last-resort guard so the run can never hang
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK96);
      #1;
   endtask

   task automatic bus_rd(input logic [2:0] addr, output logic [7:0] d);
      int n;
      M68_CS = 1'b1; M68_RW = 1'b1; M68_ADDR = addr;
      n = 0;
      do begin
         tick();
         n++;
      end while (M68_DTACK_N && n < 20);
      check("rd_latency", n, 1);
      d = M68_DOUT;
      M68_CS = 1'b0;
      tick();
   endtask

   task automatic bus_wr(input logic [2:0] addr, input logic [7:0] data);
      int n;
      M68_CS = 1'b1; M68_RW = 1'b0; M68_ADDR = addr; M68_DIN = data;
      n = 0;
      do begin
         tick();
         n++;
      end while (M68_DTACK_N && n < 300);
      check("wr_ack", M68_DTACK_N, 0);
      M68_CS = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0] d;
      int n, nn, lowcnt;

      RESET96_N = 1'b0; M68_CS = 1'b0; M68_RW = 1'b1; M68_ADDR = 3'd0; M68_DIN = 8'h00;
      WAIT = 1'b0; SNDIRQ = 1'b0; SOUNDLATCH3 = 8'h00; SOUNDLATCH4 = 8'h00;
      repeat (3) tick();
      check("rst_dout", M68_DOUT, 8'hFF);
      check("rst_dtack", M68_DTACK_N, 1);
      check("rst_irq", M68_IRQ_N, 1);
      check("rst_sl", SOUNDLATCH, 8'h00);
      check("rst_cs", CS, 0);
      check("rst_nmi", NMI, 0);
      RESET96_N = 1'b1;
      tick();

      // Reads: idle status, unmapped and write-only offsets, reply latches
      bus_rd(3'd4, d); check("status_idle", d, 8'h00);
      bus_rd(3'd7, d); check("rd_off7", d, 8'hFF);
      bus_rd(3'd0, d); check("rd_off0", d, 8'hFF);
      SOUNDLATCH3 = 8'h3E; SOUNDLATCH4 = 8'hA7;
      bus_rd(3'd2, d); check("rd_sl3", d, 8'h3E);
      bus_rd(3'd3, d); check("rd_sl4", d, 8'hA7);
      check("dtack_release", M68_DTACK_N, 1);

      // Basic transfer: latches, 8-cycle strobe, busy until WAIT falls
      bus_wr(3'd0, 8'h5A);
      bus_wr(3'd1, 8'hC3);
      check("sl_5a", SOUNDLATCH, 8'h5A);
      check("sl2_c3", SOUNDLATCH2, 8'hC3);
      M68_CS = 1'b1; M68_RW = 1'b0; M68_ADDR = 3'd5; M68_DIN = 8'h00;
      tick();
      check("trig_dtack", M68_DTACK_N, 0);
      n = int'(CS); nn = int'(NMI);
      M68_CS = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (i == 3) WAIT = 1'b1;
         tick();
         n += int'(CS); nn += int'(NMI);
      end
      check("cs_width", n, 8);
      check("nmi_width", nn, 8);
      bus_rd(3'd4, d); check("status_busy", d, 8'h01);
      WAIT = 1'b0;
      tick(); tick();
      bus_rd(3'd4, d); check("status_done", d, 8'h00);

      // Offset-0 write stalled while in ACKWAIT
      bus_wr(3'd5, 8'h00);
      WAIT = 1'b1;
      repeat (12) tick();
      M68_CS = 1'b1; M68_RW = 1'b0; M68_ADDR = 3'd0; M68_DIN = 8'h11;
      lowcnt = 0;
      repeat (5) begin
         tick();
         if (!M68_DTACK_N) lowcnt++;
      end
      check("stall_dtack", lowcnt, 0);
      check("stall_sl", SOUNDLATCH, 8'h5A);
      WAIT = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (M68_DTACK_N && n < 20);
      check("stall_release_lat", n, 2);
      check("stall_commit", SOUNDLATCH, 8'h11);
      M68_CS = 1'b0;
      tick();
      check("stall_dtack_hi", M68_DTACK_N, 1);

      // Trigger held for a long CS assertion commits only once
      M68_CS = 1'b1; M68_RW = 1'b0; M68_ADDR = 3'd5;
      for (int i = 0; i < 30; i++) begin
         if (i == 2) WAIT = 1'b1;
         if (i == 12) WAIT = 1'b0;
         tick();
      end
      check("once_cs", CS, 0);
      M68_CS = 1'b0;
      tick();
      bus_rd(3'd4, d); check("once_status", d, 8'h00);

      // Interrupt flag, acknowledge, and set-wins collision
      SNDIRQ = 1'b1; tick(); SNDIRQ = 1'b0;
      check("irq_set", M68_IRQ_N, 0);
      bus_rd(3'd4, d); check("status_irq", d, 8'h02);
      bus_wr(3'd6, 8'h00);
      check("irq_ack", M68_IRQ_N, 1);
      SNDIRQ = 1'b1; tick(); SNDIRQ = 1'b0;
      M68_CS = 1'b1; M68_RW = 1'b0; M68_ADDR = 3'd6; SNDIRQ = 1'b1;
      tick();
      SNDIRQ = 1'b0;
      check("coll_dtack", M68_DTACK_N, 0);
      check("coll_irq", M68_IRQ_N, 0);
      M68_CS = 1'b0;
      tick();
      check("coll_irq_hold", M68_IRQ_N, 0);
      bus_wr(3'd6, 8'h00);
      check("irq_ack2", M68_IRQ_N, 1);

      // Watchdog behaviour with WAIT never raised
      bus_wr(3'd5, 8'h00);
      repeat (97) tick();
      bus_rd(3'd4, d); check("tout_before", d, 8'h01);
`ifdef BAKRAID_SND_TIMEOUT_EN
      bus_rd(3'd4, d); check("tout_after", d, 8'h04);
      bus_wr(3'd5, 8'h00);
      WAIT = 1'b1;
      repeat (12) tick();
      WAIT = 1'b0;
      tick(); tick();
      bus_rd(3'd4, d); check("tout_cleared", d, 8'h00);
`else
      repeat (100) tick();
      bus_rd(3'd4, d); check("no_tout_busy", d, 8'h01);
      WAIT = 1'b1; tick(); WAIT = 1'b0;
      tick(); tick();
      bus_rd(3'd4, d); check("no_tout_done", d, 8'h00);
`endif

      // Reset asserted mid-PULSE aborts the transfer
      SNDIRQ = 1'b1; tick(); SNDIRQ = 1'b0;
      bus_wr(3'd5, 8'h00);
      tick(); tick();
      check("mid_cs_high", CS, 1);
      RESET96_N = 1'b0;
      #1;
      check("rst_mid_cs", CS, 0);
      check("rst_mid_nmi", NMI, 0);
      check("rst_mid_sl", SOUNDLATCH, 8'h00);
      check("rst_mid_irq", M68_IRQ_N, 1);
      #3;
      RESET96_N = 1'b1;
      tick();
      bus_rd(3'd4, d); check("rst_mid_status", d, 8'h00);
      n = 0;
      repeat (10) begin
         tick();
         n += int'(CS);
      end
      check("rst_no_resume", n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bakraid_snd_host.md
BAKRAID_SND_HOST -- requirements
Module: bakraid_snd_host

Interface
REQ-001 SHALL have parameter PULSE_W, default 8, giving the CS/NMI pulse width in CLK96 cycles (range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 960000, giving the acknowledge watchdog limit in CLK96 cycles.
REQ-003 SHALL have port CLK96, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET96_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port M68_CS, input, 1 bit: 68k register-access select (level).
REQ-006 SHALL have port M68_RW, input, 1 bit: 1 = read, 0 = write.
REQ-007 SHALL have port M68_ADDR, input, 3 bits: register offset.
REQ-008 SHALL have port M68_DIN, input, 8 bits: write data.
REQ-009 SHALL have port M68_DOUT, output, 8 bits: read data.
REQ-010 SHALL have port M68_DTACK_N, output, 1 bit: active-low cycle acknowledge.
REQ-011 SHALL have port M68_IRQ_N, output, 1 bit: active-low sound-to-host interrupt.
REQ-012 SHALL have ports SOUNDLATCH and SOUNDLATCH2, output, 8 bits each: command bytes to the sound CPU.
REQ-013 SHALL have ports CS and NMI, output, 1 bit each: rising-edge command strobes to the sound side.
REQ-014 SHALL have ports WAIT and SNDIRQ, input, 1 bit each: sound-side busy level and single-cycle IRQ pulse.
REQ-015 SHALL have ports SOUNDLATCH3 and SOUNDLATCH4, input, 8 bits each: reply bytes from the sound CPU.

Function
REQ-016 SHALL implement this register map: 0 W SOUNDLATCH; 1 W SOUNDLATCH2; 2 R SOUNDLATCH3; 3 R SOUNDLATCH4; 4 R status {5'b0,TOUT,IRQP,BUSY}; 5 W trigger (data ignored); 6 W IRQ acknowledge; any other offset reads 8'hFF and ignores writes.
REQ-017 SHALL register M68_DOUT and assert M68_DTACK_N low 1 cycle after M68_CS is sampled high, except for stalled writes (REQ-019); DTACK_N SHALL return high the cycle after M68_CS falls.
REQ-018 SHALL commit each write exactly once per M68_CS assertion, regardless of how long CS is held.
REQ-019 SHALL stall writes to offsets 0, 1 and 5 (DTACK_N held high, no commit) while the FSM is not IDLE, and SHALL commit and acknowledge them on the first cycle IDLE is reached.
REQ-020 SHALL run an FSM with states IDLE, PULSE and ACKWAIT; BUSY = (state != IDLE).
REQ-021 SHALL, on an offset-5 write committed in IDLE, clear TOUT and the seen flag, enter PULSE, and drive CS=NMI=1 for exactly PULSE_W cycles starting the next cycle.
REQ-022 SHALL set the seen flag on any cycle in PULSE or ACKWAIT where WAIT=1.
REQ-023 SHALL move PULSE->ACKWAIT after PULSE_W cycles, and ACKWAIT->IDLE on the first cycle with seen=1 and WAIT=0.
REQ-024 SHALL set IRQP on an SNDIRQ pulse; IRQP SHALL clear on an offset-6 write; if both occur in the same cycle, set SHALL win; M68_IRQ_N = !IRQP.
REQ-025 SHALL return SOUNDLATCH3/4 as sampled in the cycle the read is accepted.

Reset
REQ-026 SHALL, while RESET96_N=0, force: state IDLE; SOUNDLATCH, SOUNDLATCH2 = 8'h00; CS, NMI, IRQP, TOUT, seen = 0; M68_DOUT = 8'hFF; M68_DTACK_N, M68_IRQ_N = 1; counters = 0.
REQ-027 SHALL abort any transfer in progress when reset is asserted, and SHALL not resume it after release.

Configuration
REQ-028 SHALL, with macro BAKRAID_SND_TIMEOUT_EN defined, count cycles spent in PULSE plus ACKWAIT; on reaching TIMEOUT the FSM SHALL go to IDLE and set TOUT=1 (cleared by the next trigger).
REQ-029 SHALL, without BAKRAID_SND_TIMEOUT_EN, omit the watchdog so that ACKWAIT waits indefinitely; status bit 2 SHALL then read 0.

Verification
REQ-030 SHALL cover: write 0<-8'h5A, 1<-8'hC3, 5<-x -> SOUNDLATCH=5A, SOUNDLATCH2=C3, CS/NMI high for 8 cycles, status=8'h01 until WAIT falls, then 8'h00.
REQ-031 SHALL cover: offset-0 write during ACKWAIT -> DTACK_N stays high and SOUNDLATCH is unchanged until WAIT falls, then the write commits and is acknowledged.
REQ-032 SHALL cover: SNDIRQ pulse -> IRQ_N=0 and status=8'h02; SNDIRQ coinciding with an offset-6 write -> IRQ_N remains 0.
REQ-033 SHALL cover, with the macro defined and TIMEOUT=100: a trigger with WAIT held low -> IDLE after 100 cycles and status=8'h04.
REQ-034 SHALL cover: RESET96_N pulsed low mid-PULSE -> CS=NMI=0 immediately, SOUNDLATCH=00, and status=00 after release.
REQ-035 SHALL cover: read offset 7 -> 8'hFF; read offset 2 with SOUNDLATCH3=8'h3E -> 8'h3E.
